// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded OP / OP_IMM / EBREAK requests into words,
// queues them with sequential byte addresses, and reports unencodable requests.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [2:0]  alu_op,
    input  logic [4:0]  alu_rs1,
    input  logic [4:0]  alu_rs2,
    input  logic [4:0]  alu_rd,
    input  logic        alu_rs2_neg,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic        err_sticky
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [31:0] EBREAK     = 32'h0010_0073;
    localparam logic [1:0]  ERR_NONE   = 2'b00;
    localparam logic [1:0]  ERR_IMM    = 2'b01;
    localparam logic [1:0]  ERR_NEG    = 2'b10;
    localparam logic [1:0]  ERR_KIND   = 2'b11;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   addr_mem  [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_valid_q;
    logic [1:0]    err_code_q;
    logic          err_sticky_q;

    logic          full, accept, push, pop, is_shift;
    logic [1:0]    enc_err;
    logic [31:0]   enc_word;
    logic [6:0]    f7;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign in_ready  = !full && !flush;
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && (enc_err == ERR_NONE);
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
    assign out_addr  = out_valid ? addr_mem[rd_ptr_q]  : 32'h0;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_sticky = err_sticky_q;

    assign f7       = alu_rs2_neg ? 7'b0100000 : 7'b0000000;
    assign is_shift = (alu_op == 3'b001) || (alu_op == 3'b101);

    // Checks run in priority order: kind, then negation legality, then immediate range.
    always_comb begin
        enc_err  = ERR_NONE;
        enc_word = 32'h0;
        unique case (in_kind)
            2'b00: begin
                if (alu_rs2_neg && alu_op != 3'b000 && alu_op != 3'b101)
                    enc_err = ERR_NEG;
                enc_word = {f7, alu_rs2, alu_rs1, alu_op, alu_rd, OPC_OP};
            end
            2'b01: begin
                if (alu_rs2_neg && alu_op != 3'b101)
                    enc_err = ERR_NEG;
                else if (is_shift ? (imm[31:5] != '0)
                                  : !((imm[31:11] == '0) || (&imm[31:11])))
                    enc_err = ERR_IMM;
                if (is_shift)
                    enc_word = {f7, imm[4:0], alu_rs1, alu_op, alu_rd, OPC_OP_IMM};
                else
                    enc_word = {imm[11:0], alu_rs1, alu_op, alu_rd, OPC_OP_IMM};
            end
            2'b10:   enc_word = EBREAK;
            default: enc_err  = ERR_KIND;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            addr_d   = BASE_ADDR;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                addr_d   = addr_q + 32'd4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            addr_q       <= BASE_ADDR;
            err_valid_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            err_valid_q <= accept && (enc_err != ERR_NONE);
            if (accept && (enc_err != ERR_NONE)) begin
                err_code_q   <= enc_err;
                err_sticky_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: out_valid gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= enc_word;
            addr_mem[wr_ptr_q]  <= addr_q;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed spec vectors followed by random traffic,
// all compared against a queue-based reference model.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk, rst_n, flush, in_valid, in_ready;
    logic [1:0]  in_kind;
    logic [2:0]  alu_op;
    logic [4:0]  alu_rs1, alu_rs2, alu_rd;
    logic        alu_rs2_neg;
    logic [31:0] imm;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_addr;
    logic        err_valid;
    logic [1:0]  err_code;
    logic        err_sticky;

    int tests  = 0;
    int failed = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_addr;
    logic        m_err_valid;
    logic [1:0]  m_err_code;
    logic        m_sticky;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd),
        .alu_rs2_neg(alu_rs2_neg), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: legality from numeric ranges of the request fields.
    function automatic void model_encode(input logic [1:0] kind, input logic [2:0] f3,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd, input logic neg,
                                         input logic [31:0] im,
                                         output logic [1:0] code, output logic [31:0] word);
        int  simm;
        bit  shift;
        code  = 2'd0;
        word  = 32'h0;
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        simm  = int'($signed(im));
        case (kind)
            2'd0: begin
                if (neg && f3 != 3'd0 && f3 != 3'd5) code = 2'd2;
                else word = {(neg ? 7'h20 : 7'h00), rs2, rs1, f3, rd, 7'h33};
            end
            2'd1: begin
                if (neg && f3 != 3'd5) code = 2'd2;
                else if (shift) begin
                    if (im > 32'd31) code = 2'd1;
                    else word = {(neg ? 7'h20 : 7'h00), im[4:0], rs1, f3, rd, 7'h13};
                end else begin
                    if (simm < -2048 || simm > 2047) code = 2'd1;
                    else word = {im[11:0], rs1, f3, rd, 7'h13};
                end
            end
            2'd2:    word = 32'h0010_0073;
            default: code = 2'd3;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_addr      = BASE;
        m_err_valid = 1'b0;
        m_err_code  = 2'd0;
        m_sticky    = 1'b0;
    endtask

    task automatic check_outputs();
        bit nonempty;
        nonempty = (exp_q.size() != 0);
        check("in_ready", in_ready, (exp_q.size() < DEPTH) && !flush);
        check("out_valid", out_valid, nonempty);
        check("out_instr", out_instr, nonempty ? exp_q[0][31:0] : 32'h0);
        check("out_addr", out_addr, nonempty ? exp_q[0][63:32] : 32'h0);
        check("err_valid", err_valid, m_err_valid);
        check("err_code", err_code, m_err_code);
        check("err_sticky", err_sticky, m_sticky);
    endtask

    // Called just after an edge with inputs set; checks, clocks once, advances the model.
    task automatic cycle();
        logic [1:0]  code;
        logic [31:0] word;
        bit          acc, pop;
        #1;
        check_outputs();
        acc = in_valid && (exp_q.size() < DEPTH) && !flush;
        pop = (exp_q.size() != 0) && out_ready;
        model_encode(in_kind, alu_op, alu_rs1, alu_rs2, alu_rd, alu_rs2_neg, imm, code, word);
        @(posedge clk);
        #1;
        m_err_valid = 1'b0;
        if (flush) begin
            exp_q.delete();
            m_addr = BASE;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                if (code != 2'd0) begin
                    m_err_valid = 1'b1;
                    m_err_code  = code;
                    m_sticky    = 1'b1;
                end else begin
                    exp_q.push_back({m_addr, word});
                    m_addr = m_addr + 32'd4;
                end
            end
        end
    endtask

    task automatic req(input logic [1:0] k, input logic [2:0] f3, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic neg,
                       input logic [31:0] im);
        in_valid = 1'b1; in_kind = k; alu_op = f3; alu_rs1 = rs1; alu_rs2 = rs2;
        alu_rd = rd; alu_rs2_neg = neg; imm = im;
        cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic head_is(input string tag, input logic [31:0] instr, input logic [31:0] addr);
        #1;
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_instr"}, out_instr, instr);
        check({tag, "_addr"}, out_addr, addr);
    endtask

    logic [31:0] edge_imm [6];

    initial begin
        edge_imm = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd31, 32'd32};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_kind = 2'd0; alu_op = 3'd0;
        alu_rs1 = 5'd0; alu_rs2 = 5'd0; alu_rd = 5'd0; alu_rs2_neg = 1'b0; imm = 32'h0;
        out_ready = 1'b0;
        model_reset();
        #3;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // add, sub, addi -1, srai 3 queued with the head stalled
        req(2'd0, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0);
        head_is("add", 32'h0020_81B3, BASE);
        req(2'd0, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0);
        head_is("stall", 32'h0020_81B3, BASE);
        req(2'd1, 3'd0, 5'd0, 5'd0, 5'd5, 1'b0, 32'hFFFF_FFFF);
        req(2'd1, 3'd5, 5'd1, 5'd0, 5'd1, 1'b1, 32'd3);
        idle(1);
        out_ready = 1'b1;
        cycle();
        head_is("sub", 32'h4020_81B3, BASE + 32'd4);
        cycle();
        head_is("addi", 32'hFFF0_0293, BASE + 32'd8);
        cycle();
        head_is("srai", 32'h4030_D093, BASE + 32'd12);
        idle(2);

        // rejects: immediate range, illegal negation, illegal kind
        req(2'd1, 3'd0, 5'd0, 5'd0, 5'd5, 1'b0, 32'd2048);
        #1;
        check("imm_err_valid", err_valid, 1'b1);
        check("imm_err_code", err_code, 2'd1);
        req(2'd1, 3'd0, 5'd0, 5'd0, 5'd5, 1'b0, 32'd5);
        head_is("after_err", 32'h0050_0293, BASE + 32'd16);
        req(2'd0, 3'd1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0);
        #1;
        check("neg_err_code", err_code, 2'd2);
        req(2'd3, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        #1;
        check("kind_err_code", err_code, 2'd3);
        idle(3);
        check("sticky_held", err_sticky, 1'b1);

        // fill with EBREAKs, then drain while still pushing
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) req(2'd2, 3'd7, 5'd9, 5'd9, 5'd9, 1'b1, 32'hDEAD);
        #1;
        check("full_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) req(2'd2, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        idle(DEPTH + 2);

        // flush with three queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) req(2'd0, 3'd4, 5'd4, 5'd5, 5'd6, 1'b0, 32'h0);
        flush = 1'b1;
        req(2'd2, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        flush = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 1'b0);
        req(2'd2, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        head_is("post_flush", 32'h0010_0073, BASE);
        out_ready = 1'b1;
        idle(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            in_valid    = ($urandom_range(0, 3) != 0);
            r           = int'($urandom_range(0, 9));
            in_kind     = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            alu_op      = 3'($urandom_range(0, 7));
            alu_rs1     = 5'($urandom);
            alu_rs2     = 5'($urandom);
            alu_rd      = 5'($urandom);
            alu_rs2_neg = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       imm = 32'($urandom_range(0, 31));
                1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2:       imm = $urandom;
                default: imm = edge_imm[$urandom_range(0, 5)];
            endcase
            flush     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        flush = 1'b0;

        // asynchronous reset with words in flight
        out_ready = 1'b0;
        req(2'd1, 3'd1, 5'd1, 5'd0, 5'd1, 1'b0, 32'd100);
        for (int i = 0; i < 3; i++) req(2'd2, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check_outputs();
        #2;
        rst_n = 1'b1;
        req(2'd2, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        head_is("post_reset", 32'h0010_0073, BASE);
        out_ready = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
